// File: rtl/clk_gen_pkg.sv
// Shared definitions for the multi-phase clock generator: bundle layout and
// the count-to-level decode used by every derived clock.
package clk_gen_pkg;

  localparam int unsigned LVL      = 0;
  localparam int unsigned RISE     = 1;
  localparam int unsigned FALL     = 2;
  localparam int unsigned BUNDLE_W = 3;

  // Level of a 50% clock of the given period that lags count 0 by offset.
  function automatic logic decode(input int unsigned cnt,
                                  input int unsigned offset,
                                  input int unsigned period);
    int unsigned w_pos;
    w_pos = (cnt + period - (offset % period)) % period;
    return (w_pos < (period / 2));
  endfunction

endpackage

// File: rtl/clk_bundle_reg.sv
// One derived clock: registered level plus single-cycle rise/fall strobes.
module clk_bundle_reg
  import clk_gen_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_freeze,
  input  logic                i_adv,
  input  logic                i_next_lvl,
  input  logic                i_rst_lvl,
  output logic [BUNDLE_W-1:0] o_bundle
);

  logic r_lvl;
  logic r_rise;
  logic r_fall;

  // Level follows the decoded next count; strobes flag a change on that edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lvl  <= i_rst_lvl;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (i_freeze) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (i_adv) begin
      r_lvl  <= i_next_lvl;
      r_rise <= i_next_lvl & ~r_lvl;
      r_fall <= ~i_next_lvl & r_lvl;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end
  end

  // Pack into the shared bundle layout.
  always_comb begin
    o_bundle       = '0;
    o_bundle[LVL]  = r_lvl;
    o_bundle[RISE] = r_rise;
    o_bundle[FALL] = r_fall;
  end

endmodule

// File: rtl/multi_phase_clk_gen.sv
// Multi-phase bus clock generator: one counter driven by the oscillator
// enable, decoded into NUM_PHASES equally spaced bus clocks plus a
// quadrature fast pair at twice the bus rate.
module multi_phase_clk_gen
  import clk_gen_pkg::*;
#(
  parameter int unsigned DIV        = 8,
  parameter int unsigned NUM_PHASES = 4,
  parameter int unsigned SYNC_VAL   = 0
) (
  input  logic                           main_clk,
  input  logic                           main_rst,
  input  logic                           ena_28m,
  input  logic                           sync_req,
  input  logic                           freeze,
  output logic [BUNDLE_W*NUM_PHASES-1:0] phase_o,
  output logic [2*BUNDLE_W-1:0]          fast_o,
  output logic [$clog2(DIV)-1:0]         phase_cnt,
  output logic                           cycle_strb
);

  localparam int unsigned CW   = $clog2(DIV);
  localparam int unsigned STEP = DIV / NUM_PHASES;
  localparam int unsigned FD   = DIV / 2;

  if ((DIV % 8) != 0) begin : g_chk_div
    $error("multi_phase_clk_gen: DIV must be a multiple of 8");
  end
  if ((DIV % NUM_PHASES) != 0) begin : g_chk_phases
    $error("multi_phase_clk_gen: DIV must be a multiple of NUM_PHASES");
  end
  if (SYNC_VAL >= DIV) begin : g_chk_sync
    $error("multi_phase_clk_gen: SYNC_VAL must be below DIV");
  end

  logic [CW-1:0]         r_cnt;
  logic                  r_cycle_strb;
  logic                  w_adv;
  logic [CW-1:0]         w_cnt_nxt;
  logic [NUM_PHASES-1:0] w_ph_nxt;
  logic [NUM_PHASES-1:0] w_ph_rst;
  logic [1:0]            w_fast_nxt;
  logic [1:0]            w_fast_rst;

  // Next count: resync load wins over the normal wrap/increment.
  always_comb begin
    w_adv = ena_28m & ~freeze;
    if (sync_req) begin
      w_cnt_nxt = CW'(SYNC_VAL);
    end else if (r_cnt == CW'(DIV - 1)) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // Decode next-count and reset-count levels for every derived clock.
  always_comb begin
    w_ph_nxt   = '0;
    w_ph_rst   = '0;
    w_fast_nxt = '0;
    w_fast_rst = '0;
    for (int unsigned k = 0; k < NUM_PHASES; k++) begin
      w_ph_nxt[k] = decode(32'(w_cnt_nxt), k * STEP, DIV);
      w_ph_rst[k] = decode(0, k * STEP, DIV);
    end
    w_fast_nxt[0] = decode(32'(w_cnt_nxt), 0, FD);
    w_fast_nxt[1] = decode(32'(w_cnt_nxt), FD / 4, FD);
    w_fast_rst[0] = decode(0, 0, FD);
    w_fast_rst[1] = decode(0, FD / 4, FD);
  end

  // Counter and cycle-start strobe; strobe only when 0 is newly entered.
  always_ff @(posedge main_clk) begin
    if (!main_rst) begin
      r_cnt        <= '0;
      r_cycle_strb <= 1'b0;
    end else if (w_adv) begin
      r_cnt        <= w_cnt_nxt;
      r_cycle_strb <= (w_cnt_nxt == '0) && (r_cnt != '0);
    end else begin
      r_cycle_strb <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_PHASES; g++) begin : g_phase
    clk_bundle_reg u_phase (
      .i_clk      (main_clk),
      .i_rst_n    (main_rst),
      .i_freeze   (freeze),
      .i_adv      (ena_28m),
      .i_next_lvl (w_ph_nxt[g]),
      .i_rst_lvl  (w_ph_rst[g]),
      .o_bundle   (phase_o[BUNDLE_W*g +: BUNDLE_W])
    );
  end

  for (genvar f = 0; f < 2; f++) begin : g_fast
    clk_bundle_reg u_fast (
      .i_clk      (main_clk),
      .i_rst_n    (main_rst),
      .i_freeze   (freeze),
      .i_adv      (ena_28m),
      .i_next_lvl (w_fast_nxt[f]),
      .i_rst_lvl  (w_fast_rst[f]),
      .o_bundle   (fast_o[BUNDLE_W*f +: BUNDLE_W])
    );
  end

  assign phase_cnt  = r_cnt;
  assign cycle_strb = r_cycle_strb;

endmodule

// File: tb/tb_multi_phase_clk_gen.sv
// Self-checking bench for multi_phase_clk_gen (default config plus a
// DIV=16 / NUM_PHASES=2 instance sharing the same stimulus).
module tb_multi_phase_clk_gen;

  logic        main_clk = 1'b0;
  logic        rst, ena, sync, frz;
  logic [11:0] phase_o;
  logic [5:0]  fast_o;
  logic [2:0]  phase_cnt;
  logic        cycle_strb;
  logic [5:0]  phase_o2;
  logic [5:0]  fast_o2;
  logic [3:0]  phase_cnt2;
  logic        cycle_strb2;

  always #5 main_clk = ~main_clk;

  multi_phase_clk_gen dut (
    .main_clk   (main_clk),
    .main_rst   (rst),
    .ena_28m    (ena),
    .sync_req   (sync),
    .freeze     (frz),
    .phase_o    (phase_o),
    .fast_o     (fast_o),
    .phase_cnt  (phase_cnt),
    .cycle_strb (cycle_strb)
  );

  multi_phase_clk_gen #(.DIV(16), .NUM_PHASES(2), .SYNC_VAL(0)) dut2 (
    .main_clk   (main_clk),
    .main_rst   (rst),
    .ena_28m    (ena),
    .sync_req   (sync),
    .freeze     (frz),
    .phase_o    (phase_o2),
    .fast_o     (fast_o2),
    .phase_cnt  (phase_cnt2),
    .cycle_strb (cycle_strb2)
  );

  typedef struct {
    logic [2:0] cnt;
    logic [3:0] pl, pr, pf;
    logic [1:0] fl, fr, ff;
    logic       cs;
  } exp_t;

  typedef struct {
    logic rst, ena, sync, frz;
    exp_t e;
  } vec_t;

  exp_t sb_q[$];
  exp_t none;
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   rec2_on = 1'b0;
  int   p0c2 = -1;
  int   p1c2 = -1;

  // Reference model state (default config: DIV=8, 4 phases, SYNC_VAL=0)
  logic [2:0] m_cnt;
  logic [3:0] m_pl;
  logic [1:0] m_fl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [3:0] dec_ph(input logic [2:0] c);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = ((int'(c) + 8 - 2 * k) % 8) < 4;
    return r;
  endfunction

  function automatic logic [1:0] dec_fast(input logic [2:0] c);
    logic [1:0] r;
    r[0] = (int'(c) % 4) < 2;
    r[1] = ((int'(c) + 3) % 4) < 2;
    return r;
  endfunction

  function automatic logic [11:0] pack_ph(input logic [3:0] l, input logic [3:0] r, input logic [3:0] f);
    logic [11:0] v;
    for (int k = 0; k < 4; k++) begin
      v[3*k]   = l[k];
      v[3*k+1] = r[k];
      v[3*k+2] = f[k];
    end
    return v;
  endfunction

  function automatic logic [5:0] pack_f(input logic [1:0] l, input logic [1:0] r, input logic [1:0] f);
    logic [5:0] v;
    for (int k = 0; k < 2; k++) begin
      v[3*k]   = l[k];
      v[3*k+1] = r[k];
      v[3*k+2] = f[k];
    end
    return v;
  endfunction

  function automatic exp_t mkexp(input logic [2:0] c, input logic [3:0] pl, input logic [3:0] pr,
                                 input logic [3:0] pf, input logic [1:0] fl, input logic [1:0] fr,
                                 input logic [1:0] ff, input logic cs);
    exp_t e;
    e.cnt = c; e.pl = pl; e.pr = pr; e.pf = pf;
    e.fl = fl; e.fr = fr; e.ff = ff; e.cs = cs;
    return e;
  endfunction

  function automatic vec_t mkvec(input logic r, input logic en, input logic sy, input logic fz, input exp_t e);
    vec_t v;
    v.rst = r; v.ena = en; v.sync = sy; v.frz = fz; v.e = e;
    return v;
  endfunction

  task automatic model_step(input logic r, input logic en, input logic sy, input logic fz, output exp_t e);
    logic [2:0] n;
    logic [3:0] np;
    logic [1:0] nf;
    e.pr = '0; e.pf = '0; e.fr = '0; e.ff = '0; e.cs = 1'b0;
    if (!r) begin
      m_cnt = '0;
      m_pl  = dec_ph(3'd0);
      m_fl  = dec_fast(3'd0);
    end else if (en && !fz) begin
      n    = sy ? 3'd0 : ((m_cnt == 3'd7) ? 3'd0 : m_cnt + 3'd1);
      np   = dec_ph(n);
      nf   = dec_fast(n);
      e.pr = np & ~m_pl;
      e.pf = ~np & m_pl;
      e.fr = nf & ~m_fl;
      e.ff = ~nf & m_fl;
      e.cs = (n == 3'd0) && (m_cnt != 3'd0);
      m_cnt = n;
      m_pl  = np;
      m_fl  = nf;
    end
    e.cnt = m_cnt;
    e.pl  = m_pl;
    e.fl  = m_fl;
  endtask

  // Drive on the falling edge and queue the expectation for the next rising edge.
  task automatic drive(input logic r, input logic en, input logic sy, input logic fz,
                       input bit use_hand, input exp_t hand);
    exp_t e;
    @(negedge main_clk);
    rst = r; ena = en; sync = sy; frz = fz;
    model_step(r, en, sy, fz, e);
    if (use_hand) sb_q.push_back(hand);
    else sb_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic en, input logic sy, input logic fz);
    drive(r, en, sy, fz, 1'b0, none);
  endtask

  task automatic goto_cnt(input logic [2:0] t);
    int g = 0;
    while (m_cnt != t && g < 16) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      g++;
    end
    if (m_cnt != t) begin
      n_chk++;
      $display("FAIL goto_cnt: model at %0d required %0d", m_cnt, t);
    end
  endtask

  // Scoreboard: compare the DUT one step after each rising edge.
  always @(posedge main_clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("phase_cnt", 32'(phase_cnt), 32'(mon_e.cnt));
      chk("phase_o", 32'(phase_o), 32'(pack_ph(mon_e.pl, mon_e.pr, mon_e.pf)));
      chk("fast_o", 32'(fast_o), 32'(pack_f(mon_e.fl, mon_e.fr, mon_e.ff)));
      chk("cycle_strb", 32'(cycle_strb), 32'(mon_e.cs));
      if (fast_o[1] || fast_o[4])
        chk("fast_rise_overlap", 32'(fast_o[1] & fast_o[4]), 32'd0);
    end
    if (rec2_on) begin
      if (phase_o2[1] && p0c2 < 0) p0c2 = int'(phase_cnt2);
      if (phase_o2[4] && p1c2 < 0) p1c2 = int'(phase_cnt2);
    end
  end

  initial begin
    vec_t tbl[17];
    rst = 1'b0; ena = 1'b0; sync = 1'b0; frz = 1'b0;
    m_cnt = '0; m_pl = '0; m_fl = '0;

    // Reset, then 16 consecutive ena pulses: two full periods.
    tbl[0] = mkvec(0, 0, 0, 0, mkexp(3'd0, 4'b1001, 4'b0000, 4'b0000, 2'b01, 2'b00, 2'b00, 0));
    tbl[1] = mkvec(1, 1, 0, 0, mkexp(3'd1, 4'b1001, 4'b0000, 4'b0000, 2'b11, 2'b10, 2'b00, 0));
    tbl[2] = mkvec(1, 1, 0, 0, mkexp(3'd2, 4'b0011, 4'b0010, 4'b1000, 2'b10, 2'b00, 2'b01, 0));
    tbl[3] = mkvec(1, 1, 0, 0, mkexp(3'd3, 4'b0011, 4'b0000, 4'b0000, 2'b00, 2'b00, 2'b10, 0));
    tbl[4] = mkvec(1, 1, 0, 0, mkexp(3'd4, 4'b0110, 4'b0100, 4'b0001, 2'b01, 2'b01, 2'b00, 0));
    tbl[5] = mkvec(1, 1, 0, 0, mkexp(3'd5, 4'b0110, 4'b0000, 4'b0000, 2'b11, 2'b10, 2'b00, 0));
    tbl[6] = mkvec(1, 1, 0, 0, mkexp(3'd6, 4'b1100, 4'b1000, 4'b0010, 2'b10, 2'b00, 2'b01, 0));
    tbl[7] = mkvec(1, 1, 0, 0, mkexp(3'd7, 4'b1100, 4'b0000, 4'b0000, 2'b00, 2'b00, 2'b10, 0));
    tbl[8] = mkvec(1, 1, 0, 0, mkexp(3'd0, 4'b1001, 4'b0001, 4'b0100, 2'b01, 2'b01, 2'b00, 1));
    for (int i = 9; i < 17; i++) tbl[i] = tbl[i-8];
    for (int i = 0; i < 17; i++)
      drive(tbl[i].rst, tbl[i].ena, tbl[i].sync, tbl[i].frz, 1'b1, tbl[i].e);

    // ena on every third cycle: idle cycles must show no strobes.
    for (int i = 0; i < 12; i++) step(1'b1, (i % 3) == 0, 1'b0, 1'b0);

    // Resync from cnt=5 to 0.
    goto_cnt(3'd5);
    drive(1, 1, 1, 0, 1'b1, mkexp(3'd0, 4'b1001, 4'b1001, 4'b0110, 2'b01, 2'b00, 2'b10, 1));
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Freeze for 5 ena pulses at cnt=3, then resume.
    goto_cnt(3'd3);
    for (int i = 0; i < 5; i++)
      drive(1, 1, 0, 1, 1'b1, mkexp(3'd3, 4'b0011, 4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 0));
    drive(1, 1, 0, 0, 1'b1, mkexp(3'd4, 4'b0110, 4'b0100, 4'b0001, 2'b01, 2'b01, 2'b00, 0));

    // Reset mid-period at cnt=6.
    goto_cnt(3'd6);
    drive(0, 1, 0, 0, 1'b1, mkexp(3'd0, 4'b1001, 4'b0000, 4'b0000, 2'b01, 2'b00, 2'b00, 0));
    @(posedge main_clk);
    #2;
    chk("dut2_rst_phase_o", 32'(phase_o2), 32'h01);
    chk("dut2_rst_fast_o", 32'(fast_o2), 32'h01);
    chk("dut2_rst_cnt", 32'(phase_cnt2), 32'd0);
    chk("dut2_rst_cycle_strb", 32'(cycle_strb2), 32'd0);
    drive(1, 1, 0, 0, 1'b1, mkexp(3'd1, 4'b1001, 4'b0000, 4'b0000, 2'b11, 2'b10, 2'b00, 0));

    // Second configuration: p1 rises 8 counts after p0.
    rec2_on = 1'b1;
    for (int i = 0; i < 24; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge main_clk);
    #2;
    rec2_on = 1'b0;
    chk("dut2_p1_rise_cnt", 32'(p1c2), 32'd8);
    chk("dut2_p0_rise_cnt", 32'(p0c2), 32'd0);

    repeat (4) @(posedge main_clk);
    #2;
    if (sb_q.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multi_phase_clk_gen.md
Name: multi_phase_clk_gen

Overview:
- Parametrised successor to the fixed Alice clock generator; derives N equally spaced bus-clock phases (C1..C4/CCK/CCKQ-style) plus a quadrature fast pair (C7M/CDAC-style) from one oscillator enable (ena_28m).
- Every derived clock is a 3-bit bundle: level, rise pulse, fall pulse. Rise and fall are single-main_clk strobes, consumed as clock enables by chipset models (PHI1/PHI2/CCKR/CCKF).
- Adds runtime phase resync, freeze, a phase-counter output and a cycle-start strobe.

Parameters:
- DIV, 8, ena_28m pulses per bus-clock period; must be a multiple of 8 and of NUM_PHASES.
- NUM_PHASES, 4, number of bus-clock phases; phase k lags phase 0 by k*STEP counts, STEP = DIV/NUM_PHASES.
- SYNC_VAL, 0, counter value loaded on resync; range 0..DIV-1.

Ports:
- main_clk  in  1  simulation/system clock; sole clock.
- main_rst  in  1  synchronous reset, active-low.
- ena_28m  in  1  oscillator enable; one main_clk cycle per oscillator tick.
- sync_req  in  1  resync request; honoured only on a cycle with ena_28m=1.
- freeze  in  1  holds all state while high.
- phase_o  out  3*NUM_PHASES  bundle k at bits [3k+2:3k]: bit0 level, bit1 rise, bit2 fall.
- fast_o  out  6  bundle 0 = fast clock (C7M), bundle 1 = quadrature copy (CDAC); same bit layout.
- phase_cnt  out  clog2(DIV)  current counter value.
- cycle_strb  out  1  one-cycle pulse when the counter enters 0.

Behaviour:
- Counter cnt advances on main_clk when ena_28m=1, freeze=0 and main_rst=1.
- Advance rule: sync_req=1 loads SYNC_VAL; otherwise DIV-1 wraps to 0, else cnt+1.
- Priority: main_rst low > freeze > sync_req > increment. When freeze=1, counter and levels hold, and all rise/fall strobes and cycle_strb are 0.
- Decode function of count c:
  - phase k level = ((c - k*STEP) mod DIV) < DIV/2.
  - FD = DIV/2. fast0 level = (c mod FD) < FD/2.
  - fast1 level = ((c - FD/4) mod FD) < FD/2.
- Levels are registered from decode(next cnt), so a level and its cnt update on the same edge.
- Strobes:
  - rise = 1 for exactly the one main_clk cycle in which the registered level first reads 1 after 0.
  - fall is the same for a 1-to-0 change.
  - Strobes are 0 in all other cycles, including non-ena_28m cycles.
  - cycle_strb = 1 in the cycle cnt first reads 0 by wrap or by resync, provided it was not already 0.
- Resync: the load takes effect on the same edge. Levels jump to decode(SYNC_VAL); any level change caused by the jump produces the corresponding rise/fall strobe. Resync to the current next value is indistinguishable from a normal advance.
- Reset (main_rst=0 at an edge):
  - cnt=0.
  - Levels = decode(0); defaults give phase levels p0=1, p1=0, p2=0, p3=1, fast0=1, fast1=0.
  - All strobes and cycle_strb = 0.
  - Reset mid-period discards state without emitting strobes.
  - First advance after reset goes to cnt=1.
- Latency: one main_clk edge from an ena_28m cycle to the updated level and strobe outputs.
- Duty cycle: all outputs are exactly 50%. The fast pair runs at 2x the bus clock with a 90 degree offset.
- Elaboration must fail when DIV%8!=0, DIV%NUM_PHASES!=0 or SYNC_VAL>=DIV.

Decomposition:
- Shared package clk_gen_pkg: bundle bit indices (LVL=0, RISE=1, FALL=2), bundle width 3, and a decode function taking count, offset and period.
- One sub-module, clk_bundle_reg: level register plus edge-strobe generation for one clock, with freeze and reset. It is instantiated NUM_PHASES+2 times.

Test Plan:
- Reset then 16 ena_28m pulses with defaults:
  - phase_cnt runs 0..7 and wraps to 0.
  - p0 rises at cnt=0 and falls at cnt=4.
  - p1 rises at cnt=2; p3 rises at cnt=6.
  - cycle_strb fires twice; each strobe lasts exactly 1 cycle.
- ena_28m every 3rd main_clk cycle: levels change only on ena edges; no strobes in the idle cycles.
- Fast pair:
  - fast0 toggles every 2 ena and rises at cnt 0 and 4.
  - fast1 rises at cnt 1 and 5.
  - fast0 rise never coincides with fast1 rise.
- sync_req at cnt=5 with SYNC_VAL=0: next cnt=0, cycle_strb=1, p0 rise strobe, p2 fall strobe.
- freeze held for 5 ena pulses at cnt=3: cnt stays 3, no strobes; resumes at 4 with p0 fall strobe.
- main_rst low at cnt=6, and NUM_PHASES=2/DIV=16: reset levels restored with zero strobes; second config gives p1 rising 8 counts after p0.
